// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcode/funct/rt
// constants, datapath select encodings and the decoded instruction class.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [2:0] BR_NONE   = 3'b000;
    localparam logic [2:0] BR_BEQ    = 3'b001;
    localparam logic [2:0] BR_BNE    = 3'b010;
    localparam logic [2:0] BR_BGEZ   = 3'b011;
    localparam logic [2:0] BR_BLTZ   = 3'b100;
    localparam logic [2:0] BR_BGTZ   = 3'b101;
    localparam logic [2:0] BR_BLEZ   = 3'b110;

    localparam logic [1:0] RD_RT     = 2'b00;
    localparam logic [1:0] RD_RD     = 2'b01;
    localparam logic [1:0] RD_RA     = 2'b10;

    localparam logic [1:0] RS_ALU    = 2'b00;
    localparam logic [1:0] RS_MEM    = 2'b01;
    localparam logic [1:0] RS_LINK   = 2'b10;
    localparam logic [1:0] RS_SLT    = 2'b11;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_SLTU  = 3'b100;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_LUI   = 2'b01;
    localparam logic [1:0] EXT_SIGN  = 2'b10;

    // One-hot instruction class; all-zero means unknown (executed as nop).
    typedef struct packed {
        logic alu_r;
        logic ori;
        logic lui;
        logic slt;
        logic lw;
        logic sw;
        logic branch;
        logic jr;
        logic j;
        logic jal;
    } cls_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. master = sequencer side,
// slave = datapath side.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rt;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       memRE;
    logic       memWE;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [2:0] br_type;
    logic       regWE;
    logic [1:0] regDst;
    logic [1:0] regStr;
    logic       ALUSrc;
    logic [2:0] ALUOp;
    logic [1:0] EXTOp;
    logic       instr_done;
    logic [2:0] state;

    modport master (
        input  op, func, rt, branch_taken, mem_ready,
        output mem_req, memRE, memWE, ir_we, pc_we, pc_src, br_type,
               regWE, regDst, regStr, ALUSrc, ALUOp, EXTOp, instr_done, state
    );

    modport slave (
        output op, func, rt, branch_taken, mem_ready,
        input  mem_req, memRE, memWE, ir_we, pc_we, pc_src, br_type,
               regWE, regDst, regStr, ALUSrc, ALUOp, EXTOp, instr_done, state
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR fields to one-hot class plus the
// static datapath selects that do not depend on the sequencer state.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    input  logic [4:0] rt_i,
    output cls_t       cls_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] ext_op_o,
    output logic       alu_src_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] reg_str_o,
    output logic [2:0] br_type_o
);

    always_comb begin
        cls_o     = '0;
        alu_op_o  = ALU_ADD;
        ext_op_o  = EXT_ZERO;
        alu_src_o = 1'b0;
        reg_dst_o = RD_RT;
        reg_str_o = RS_ALU;
        br_type_o = BR_NONE;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU: begin
                        cls_o.alu_r = 1'b1;
                        reg_dst_o   = RD_RD;
                    end
                    FN_SUBU: begin
                        cls_o.alu_r = 1'b1;
                        alu_op_o    = ALU_SUB;
                        reg_dst_o   = RD_RD;
                    end
                    FN_JR:   cls_o.jr = 1'b1;
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt_i)
                    RT_BGEZ: begin
                        cls_o.branch = 1'b1;
                        br_type_o    = BR_BGEZ;
                        ext_op_o     = EXT_SIGN;
                    end
                    RT_BLTZ: begin
                        cls_o.branch = 1'b1;
                        br_type_o    = BR_BLTZ;
                        ext_op_o     = EXT_SIGN;
                    end
                    default: ;
                endcase
            end
            OP_J:   cls_o.j = 1'b1;
            OP_JAL: begin
                cls_o.jal = 1'b1;
                reg_dst_o = RD_RA;
                reg_str_o = RS_LINK;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                cls_o.branch = 1'b1;
                ext_op_o     = EXT_SIGN;
                case (op_i)
                    OP_BEQ:  br_type_o = BR_BEQ;
                    OP_BNE:  br_type_o = BR_BNE;
                    OP_BLEZ: br_type_o = BR_BLEZ;
                    default: br_type_o = BR_BGTZ;
                endcase
            end
            OP_SLTI, OP_SLTIU: begin
                cls_o.slt = 1'b1;
                alu_op_o  = (op_i == OP_SLTI) ? ALU_SLT : ALU_SLTU;
                ext_op_o  = EXT_SIGN;
                alu_src_o = 1'b1;
                reg_str_o = RS_SLT;
            end
            OP_ORI: begin
                cls_o.ori = 1'b1;
                alu_op_o  = ALU_OR;
                alu_src_o = 1'b1;
            end
            OP_LUI: begin
                cls_o.lui = 1'b1;
                alu_op_o  = ALU_OR;
                ext_op_o  = EXT_LUI;
                alu_src_o = 1'b1;
            end
            OP_LW: begin
                cls_o.lw  = 1'b1;
                ext_op_o  = EXT_SIGN;
                alu_src_o = 1'b1;
                reg_str_o = RS_MEM;
            end
            OP_SW: begin
                cls_o.sw  = 1'b1;
                ext_op_o  = EXT_SIGN;
                alu_src_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB state machine driving
// datapath strobes and selects, stalling on the shared memory port.
module mc_controller
    import mc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_e     state_q, state_d;
    cls_t       cls;
    logic       known;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_ext_op;
    logic       dec_alu_src;
    logic [1:0] dec_reg_dst;
    logic [1:0] dec_reg_str;
    logic [2:0] dec_br_type;

    mc_decode u_decode (
        .op_i      (bus.op),
        .func_i    (bus.func),
        .rt_i      (bus.rt),
        .cls_o     (cls),
        .alu_op_o  (dec_alu_op),
        .ext_op_o  (dec_ext_op),
        .alu_src_o (dec_alu_src),
        .reg_dst_o (dec_reg_dst),
        .reg_str_o (dec_reg_str),
        .br_type_o (dec_br_type)
    );

    assign known     = |cls;
    assign bus.state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = (cls.j || !known) ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if (cls.lw || cls.sw)
                    state_d = ST_MEM;
                else if (cls.alu_r || cls.ori || cls.lui || cls.slt || cls.jal)
                    state_d = ST_WB;
                else
                    state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (!bus.mem_ready) state_d = ST_MEM;
                else if (cls.lw)    state_d = ST_WB;
                else                state_d = ST_FETCH;
            end
            default:   state_d = ST_FETCH;
        endcase
    end

    // Reset gates every output so an abandoned instruction cannot commit anything.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.memRE      = 1'b0;
        bus.memWE      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = PC_PLUS4;
        bus.br_type    = BR_NONE;
        bus.regWE      = 1'b0;
        bus.regDst     = RD_RT;
        bus.regStr     = RS_ALU;
        bus.ALUSrc     = 1'b0;
        bus.ALUOp      = ALU_ADD;
        bus.EXTOp      = EXT_ZERO;
        bus.instr_done = 1'b0;
        if (!reset) begin
            if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
                bus.ALUSrc = dec_alu_src;
                bus.ALUOp  = dec_alu_op;
                bus.EXTOp  = dec_ext_op;
            end
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.memRE   = 1'b1;
                    bus.ir_we   = bus.mem_ready;
                    bus.pc_we   = bus.mem_ready;
                end
                ST_DECODE: begin
                    if (cls.j) begin
                        bus.pc_we      = 1'b1;
                        bus.pc_src     = PC_JUMP;
                        bus.instr_done = 1'b1;
                    end else if (!known) begin
                        bus.instr_done = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cls.branch) begin
                        bus.br_type    = dec_br_type;
                        bus.pc_we      = bus.branch_taken;
                        bus.pc_src     = PC_BRANCH;
                        bus.instr_done = 1'b1;
                    end else if (cls.jr) begin
                        bus.pc_we      = 1'b1;
                        bus.pc_src     = PC_RS;
                        bus.instr_done = 1'b1;
                    end else if (cls.jal) begin
                        bus.pc_we      = 1'b1;
                        bus.pc_src     = PC_JUMP;
                    end
                end
                ST_MEM: begin
                    bus.mem_req    = 1'b1;
                    bus.memRE      = cls.lw;
                    bus.memWE      = cls.sw;
                    bus.instr_done = cls.sw && bus.mem_ready;
                end
                ST_WB: begin
                    bus.regWE      = 1'b1;
                    bus.instr_done = 1'b1;
                    bus.regDst     = dec_reg_dst;
                    bus.regStr     = dec_reg_str;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle sequencer for the MIPS datapath. It is a state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes and mux selects in each state. It stalls on a shared instruction/data memory port through a req/ready handshake. It sits beside the datapath: it reads op/func/rt from the datapath's instruction register and branch_taken from the datapath comparator.

Parameters:
none (all encodings fixed by the shared package)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
op  in  6  IR[31:26]
func  in  6  IR[5:0]
rt  in  5  IR[20:16], selects bgez/bltz under op=000001
branch_taken  in  1  datapath comparator result for br_type
mem_ready  in  1  memory done this cycle
mem_req  out  1  memory access request
memRE  out  1  read (fetch or lw)
memWE  out  1  write (sw)
ir_we  out  1  load IR
pc_we  out  1  load PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
br_type  out  3  000 none, 001 beq, 010 bne, 011 bgez, 100 bltz, 101 bgtz, 110 blez
regWE  out  1  register file write
regDst  out  2  00 rt, 01 rd, 10 $31
regStr  out  2  write data: 00 ALU, 01 memory, 10 link (latched PC+4), 11 set-less result
ALUSrc  out  1  0 rt, 1 extended immediate
ALUOp  out  3  000 add, 001 sub, 010 or, 011 slt, 100 sltu
EXTOp  out  2  00 zero, 01 lui shift, 10 sign
instr_done  out  1  one-cycle pulse on each instruction's final state
state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Registered state; all outputs are combinational from state, decoded IR and mem_ready.
- Reset: on the edge where reset=1, state <= FETCH. While reset is high, every strobe (mem_req, memRE, memWE, ir_we, pc_we, regWE, instr_done) is forced 0 and every select is forced 0. A reset mid-instruction abandons it: no partial writes after that edge.
- FETCH: mem_req=1, memRE=1. Hold FETCH while mem_ready=0. When mem_ready=1: ir_we=1, pc_we=1, pc_src=00, and go to DECODE. Zero-wait operation is legal (ready in the same cycle as req).
- DECODE: no strobes. EXTOp/ALUSrc are driven per the decoded class.
  - j: pc_we=1, pc_src=10, instr_done=1, then FETCH.
  - Unknown opcode/funct: treated as nop; instr_done=1, then FETCH.
  - All others: go to EXEC.
- EXEC, by class:
  - addu/subu: ALUOp add/sub, ALUSrc=0, then WB.
  - ori: ALUOp or, EXTOp zero, then WB.
  - lui: ALUOp or, EXTOp lui, then WB.
  - slti/sltiu: ALUOp slt/sltu, EXTOp sign, then WB.
  - lw/sw: ALUOp add, EXTOp sign, ALUSrc=1, then MEM.
  - Branches: br_type set, ALUSrc=0, EXTOp sign. pc_we=branch_taken, pc_src=01. instr_done=1, then FETCH.
  - jr: pc_we=1, pc_src=11, instr_done=1, then FETCH.
  - jal: pc_we=1, pc_src=10, then WB.
- MEM: mem_req=1, with memRE (lw) or memWE (sw). Hold MEM while mem_ready=0. memWE stays asserted for the whole wait, and the datapath commits the write only on the ready cycle. When ready: lw goes to WB; sw sets instr_done=1 and goes to FETCH.
- WB: regWE=1 for exactly one cycle, instr_done=1, then FETCH. Selects by class:
  - R-type: regDst=01, regStr=00.
  - I-type ALU: regDst=00, regStr=00.
  - slt*: regStr=11.
  - lw: regStr=01.
  - jal: regDst=10, regStr=10.
- CPI: j=2; branch/jr=3; R/I ALU/sw/jal=4; lw=5. Each memory wait cycle adds one.
- regWE, memWE and pc_we are never asserted in the same cycle, except pc_we with ir_we in FETCH.
- Unused states 5-7: go to FETCH with no strobes.

Decomposition:
- Shared package mc_pkg: state encodings; opcode, funct and rt constants; and the pc_src, br_type, regDst, regStr, ALUOp and EXTOp encodings.
- Sub-module mc_decode: purely combinational. Maps op/func/rt to a one-hot class vector and to static selects (ALUOp, EXTOp, ALUSrc, regDst, regStr, br_type).
- mc_controller holds only the FSM and the strobe generation.

Test Plan:
- Reset held 3 cycles mid-MEM (sw, mem_ready=0) -> memWE drops in the reset cycle, state=0 after the edge, no regWE/pc_we pulse.
- addu (op=0, func=0x21) with mem_ready tied 1 -> states 0,1,2,4; regWE=1 only in WB with regDst=01; instr_done on cycle 4.
- lw (op=0x23) with ready delayed 2 cycles in FETCH and 3 cycles in MEM -> 5+2+3=10 cycles; memRE high throughout both waits; regStr=01 in WB.
- beq (op=4) with branch_taken=0, then again with branch_taken=1 -> pc_we=0 / pc_we=1 with pc_src=01 in EXEC; 3 cycles each; regWE never set.
- jal (op=3) -> pc_we with pc_src=10 in EXEC; regWE with regDst=10, regStr=10 in WB. j (op=2) -> 2 cycles.
- bgez (op=1, rt=1) -> br_type=011. Undefined op=0x3F -> 2-cycle nop with instr_done, no writes.
